// File: rtl/grom_sram_arb.sv
// Arbiter/sequencer for the shared external 8-bit async SRAM: loader, CPU and GROM requesters.
// Fixed wait-state access, one-cycle ack pulse, one bus-turnaround cycle after each access.
module grom_sram_arb #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [19:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        grom_req,
  input  logic [19:0] grom_addr,
  output logic        grom_ack,
  output logic [7:0]  rdata,
  output logic [19:0] sram_addr,
  input  logic [7:0]  sram_din,
  output logic [7:0]  sram_dout,
  output logic        sram_drive,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  localparam logic [1:0] OWN_LDR  = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_GROM = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [1:0]  owner;
  logic [3:0]  cnt;
  logic        rr_last_cpu;
  logic        is_write;

  logic        grant;
  logic [1:0]  grant_owner;
  logic        grant_we;
  logic [19:0] grant_addr;
  logic [7:0]  grant_wdata;

  // Loader wins outright; CPU/GROM alternate when both are asking.
  always_comb begin
    grant       = ldr_req | cpu_req | grom_req;
    grant_owner = OWN_GROM;
    grant_we    = 1'b0;
    grant_addr  = grom_addr;
    grant_wdata = 8'h00;
    if (ldr_req) begin
      grant_owner = OWN_LDR;
      grant_we    = ldr_we;
      grant_addr  = ldr_addr;
      grant_wdata = ldr_wdata;
    end else if (cpu_req && (!grom_req || !rr_last_cpu)) begin
      grant_owner = OWN_CPU;
      grant_we    = cpu_we;
      grant_addr  = cpu_addr;
      grant_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_LDR;
      cnt         <= 4'd0;
      rr_last_cpu <= 1'b0;
      is_write    <= 1'b0;
      ldr_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      grom_ack    <= 1'b0;
      rdata       <= 8'h00;
      sram_addr   <= 20'h00000;
      sram_dout   <= 8'h00;
      sram_drive  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      ldr_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      grom_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= grant_owner;
            is_write   <= grant_we;
            sram_addr  <= grant_addr;
            sram_dout  <= grant_wdata;
            cnt        <= CNT_INIT;
            state      <= ACCESS;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= grant_we;
            sram_drive <= grant_we;
            if (grant_owner != OWN_LDR) rr_last_cpu <= (grant_owner == OWN_CPU);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            // WE held off for the first cycle to give address setup.
            if (is_write) sram_we_n <= 1'b0;
          end else begin
            if (!is_write) rdata <= sram_din;
            case (owner)
              OWN_LDR: ldr_ack  <= 1'b1;
              OWN_CPU: cpu_ack  <= 1'b1;
              default: grom_ack <= 1'b1;
            endcase
            state      <= RECOVER;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_drive <= 1'b0;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/grom_sram_arb.md
Name: grom_sram_arb

Overview:
Arbiter and sequencer for the single external 8-bit async SRAM that backs the 1 MB GROM space, CPU-mapped RAM/ROM and the host loader. The arbiter grants one requester at a time and drives SRAM strobes with a fixed wait-state count. It returns read data with a one-cycle acknowledge. It sits between the GROM address generator, the CPU memory decoder and the SPI/serial loader on one side, and the FPGA SRAM pins on the other.

Parameters:
WAIT_CYCLES, 2, extra ACCESS cycles beyond the first; legal range 1..15.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ldr_req  in  1  loader request, level; held until ldr_ack
ldr_we  in  1  loader write (1) / read (0)
ldr_addr  in  20  loader byte address
ldr_wdata  in  8  loader write data
ldr_ack  out  1  loader completion pulse, 1 cycle
cpu_req  in  1  CPU request, level
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  20  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  CPU completion pulse
grom_req  in  1  GROM read request, level; read-only port
grom_addr  in  20  GROM byte address
grom_ack  out  1  GROM completion pulse
rdata  out  8  read data of last completed read, shared by all ports
sram_addr  out  20  SRAM address
sram_din  in  8  data from SRAM pins
sram_dout  out  8  data to SRAM pins
sram_drive  out  1  1 = FPGA drives SRAM data bus
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset values: all acks 0, rdata 0x00, sram_addr 0, sram_dout 0, sram_drive 0, sram_ce_n/oe_n/we_n 1. State IDLE, cnt 0, rr_last_cpu 0.
- All outputs are registered.
- States: IDLE, ACCESS, RECOVER.
- IDLE: sample requests each edge. Priority order:
  - ldr_req has absolute priority.
  - Otherwise, if both cpu_req and grom_req are high, grant the one not granted last (rr_last_cpu=1 -> grom, 0 -> cpu).
  - Otherwise grant whichever is high.
- On grant: latch owner, we (forced 0 for grom), addr and wdata. Set cnt=WAIT_CYCLES. Go to ACCESS. Update rr_last_cpu only on cpu/grom grants.
- ACCESS lasts WAIT_CYCLES+1 cycles. Signals during ACCESS:
  - sram_addr is stable for the whole of ACCESS and RECOVER.
  - sram_ce_n is 0 for the whole of ACCESS.
  - Read: sram_oe_n=0 and sram_drive=0 for all ACCESS cycles.
  - Write: sram_drive=1 and sram_dout=wdata for all ACCESS cycles. sram_we_n=0 from the 2nd ACCESS cycle through the last, which gives one cycle of address setup before WE.
- Each ACCESS edge: if cnt!=0, cnt decrements. If cnt==0:
  - For a read, rdata<=sram_din.
  - Assert the owner's ack for exactly one cycle.
  - Go to RECOVER.
- RECOVER: one cycle with all strobes inactive and sram_drive=0 (bus turnaround). The ack is high during this cycle. Then go to IDLE.
- Latency: request sampled at edge E0 -> ack high in the cycle following edge E0+WAIT_CYCLES+1. Back-to-back grants are separated by ≥1 IDLE cycle. Default occupancy is 5 cycles per access.
- Requester rule: req must drop at or before the edge following its ack. A req still high in IDLE after its ack is treated as a new request (and is a requester protocol error).
- Requests arriving during ACCESS/RECOVER wait; none are lost as long as req is held.
- rdata is unchanged by writes. It holds its value until the next read completes.
- Reset mid-operation: next edge forces IDLE with strobes inactive and acks 0. The in-flight access never acks, and a write may be truncated.
- Address and wdata inputs are ignored except at the grant edge.

Test Plan:
- Single CPU read, WAIT_CYCLES=2, sram_din=0xA5 at 0x01234 -> oe_n low 3 cycles, cpu_ack one pulse 4 cycles after request sampled, rdata=0xA5.
- Loader write 0x5A to 0xFFFFF -> sram_drive high 3 cycles, we_n low exactly 2 cycles (not the first), ldr_ack pulse, rdata unchanged.
- cpu_req and grom_req held high continuously (grom dropping/reasserting per protocol) -> grants alternate cpu, grom, cpu, grom; each grant has exactly one matching ack.
- ldr_req raised during a CPU access with grom_req also pending -> CPU completes, loader granted next, then grom.
- reset asserted in 2nd ACCESS cycle of a write -> next cycle we_n/ce_n=1, drive=0, no ack; a new request after reset completes normally.
- WAIT_CYCLES=1 build, GROM read -> ACCESS 2 cycles, ack 3 cycles after sample, rdata=sram_din.
